// File: rtl/sr_cmd_debounce.sv
// Synchronise and debounce the set/clear push-buttons into SR flip-flop commands, never driving s=r=1.
// Optional build macro SR_CMD_HOLD_EN: level (hold) outputs instead of one-cycle pulses.
module sr_cmd_debounce #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic clr_btn,
  output logic s,
  output logic r,
  output logic conflict
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel index 0 is the set button, index 1 the clear button.
  logic [1:0]       btn;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       stable;
  logic [1:0]       stable_prev;
  logic [CNT_W-1:0] cnt [2];

  logic set_stable;
  logic clr_stable;
  logic set_rise;
  logic clr_rise;
  logic s_next;
  logic r_next;
  logic conflict_next;

  assign btn = {clr_btn, set_btn};

  // Any sample matching the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      stable      <= '0;
      stable_prev <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1       <= btn;
      sync2       <= sync1;
      stable_prev <= stable;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign set_stable = stable[0];
  assign clr_stable = stable[1];
  assign set_rise   = stable[0] & ~stable_prev[0];
  assign clr_rise   = stable[1] & ~stable_prev[1];

`ifdef SR_CMD_HOLD_EN
  always_comb begin
    s_next        = set_stable & ~clr_stable;
    r_next        = clr_stable & ~set_stable;
    conflict_next = set_stable & clr_stable;
  end
`else
  // A rise is suppressed whenever the other channel is already (or simultaneously) high.
  always_comb begin
    s_next        = 1'b0;
    r_next        = 1'b0;
    conflict_next = 1'b0;
    if (set_rise && clr_rise) begin
      conflict_next = 1'b1;
    end else if (set_rise) begin
      if (clr_stable) conflict_next = 1'b1;
      else            s_next        = 1'b1;
    end else if (clr_rise) begin
      if (set_stable) conflict_next = 1'b1;
      else            r_next        = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s        <= s_next;
      r        <= r_next;
      conflict <= conflict_next;
    end
  end

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Self-checking bench for sr_cmd_debounce: per-edge vector table plus hand-written corner sequences.
module tb_sr_cmd_debounce;

  logic clk;
  logic rst;
  logic set_btn;
  logic clr_btn;
  logic s;
  logic r;
  logic conflict;
  logic s1;
  logic r1;
  logic conflict1;

  int n_checks;
  int n_fail;

  typedef struct {
    string name;
    int    row;
    logic  rst;
    logic  set_btn;
    logic  clr_btn;
    logic  exp_s;
    logic  exp_r;
    logic  exp_conflict;
  } vec_t;

  vec_t vecs[$];

  sr_cmd_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
    .s(s), .r(r), .conflict(conflict)
  );

  // Minimum legal debounce length: a single mismatching sample is accepted.
  sr_cmd_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) dut_min (
    .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
    .s(s1), .r(r1), .conflict(conflict1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add_vec(string name, int row, logic rst_v, logic set_v, logic clr_v,
                                  logic s_v, logic r_v, logic c_v);
    vec_t v;
    v.name = name; v.row = row; v.rst = rst_v; v.set_btn = set_v; v.clr_btn = clr_v;
    v.exp_s = s_v; v.exp_r = r_v; v.exp_conflict = c_v;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(string name, logic actual, logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Inputs for edge k are driven before that edge; outputs are sampled on the following negedge.
  task automatic applyStimulus(logic rst_v, logic set_v, logic clr_v);
    rst     = rst_v;
    set_btn = set_v;
    clr_btn = clr_v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkRow(string tag, int k, logic es, logic er, logic ec);
    checkOutput($sformatf("%s.s@%0d", tag, k), s, es);
    checkOutput($sformatf("%s.r@%0d", tag, k), r, er);
    checkOutput($sformatf("%s.conflict@%0d", tag, k), conflict, ec);
    checkOutput($sformatf("%s.s_and_r@%0d", tag, k), s & r, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    set_btn  = 1'b0;
    clr_btn  = 1'b0;

`ifdef SR_CMD_HOLD_EN
    // Set held on edges 3..22, clear overlaps on edges 10..14.
    for (int k = 0; k < 32; k++) begin
      logic set_st_prev;
      logic clr_st_prev;
      applyStimulus(k < 2, (k >= 3) && (k <= 22), (k >= 10) && (k <= 14));
      set_st_prev = (k - 1 >= 8) && (k - 1 <= 27);
      clr_st_prev = (k - 1 >= 15) && (k - 1 <= 19);
      checkRow("hold", k, set_st_prev & ~clr_st_prev, clr_st_prev & ~set_st_prev,
               set_st_prev & clr_st_prev);
    end
`else
    // Set held from edge 3: single s pulse after edge 9, release gives nothing.
    for (int k = 0; k < 23; k++)
      add_vec("set_press", k, k < 2, (k >= 3) && (k <= 12), 1'b0, k == 9, 1'b0, 1'b0);
    // Clear bounces 1,0,1,0 on edges 3..6, then held from edge 7: r after edge 13.
    for (int k = 0; k < 28; k++)
      add_vec("clr_bounce", k, k < 2, 1'b0,
              (k == 3) || (k == 5) || ((k >= 7) && (k <= 20)), 1'b0, k == 13, 1'b0);
    // Both buttons rise on edge 3: one conflict after edge 9, never s or r.
    for (int k = 0; k < 23; k++)
      add_vec("both_rise", k, k < 2, (k >= 3) && (k <= 14), (k >= 3) && (k <= 14),
              1'b0, 1'b0, k == 9);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].set_btn, vecs[i].clr_btn);
      checkRow(vecs[i].name, vecs[i].row, vecs[i].exp_s, vecs[i].exp_r, vecs[i].exp_conflict);
    end

    // Clear held, set pressed on top of it, then both released and set re-pressed.
    for (int k = 0; k < 45; k++) begin
      applyStimulus(k < 2, ((k >= 12) && (k < 22)) || (k >= 32), (k >= 3) && (k < 22));
      checkRow("set_over_clr", k, k == 38, k == 9, k == 18);
    end

    // Reset two counts into the set debounce window, button still held.
    for (int k = 0; k < 21; k++) begin
      applyStimulus((k < 2) || (k == 7) || (k == 8), k >= 3, 1'b0);
      checkRow("mid_reset", k, k == 15, 1'b0, 1'b0);
    end

    // Short hold and a one-sample glitch against both debounce lengths.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(k < 2, (k >= 3) && (k <= 7), 1'b0);
      checkRow("short_hold", k, k == 9, 1'b0, 1'b0);
      checkOutput($sformatf("min.s@%0d", k), s1, k == 6);
      checkOutput($sformatf("min.r@%0d", k), r1, 1'b0);
    end
    for (int k = 0; k < 12; k++) begin
      applyStimulus(k < 2, k == 3, 1'b0);
      checkRow("glitch", k, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("min_glitch.s@%0d", k), s1, k == 6);
      checkOutput($sformatf("min_glitch.conflict@%0d", k), conflict1, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
